// File: rtl/boreal_pkg.sv
// Shared constants and FSM state type for the ADS-style frame emulator.
package boreal_pkg;
  localparam int FRAME_BITS = 792;
  localparam int WORD_BITS  = 24;
  localparam logic [WORD_BITS-1:0] STATUS_WORD = 24'hC00000;

  typedef enum logic [1:0] {ST_IDLE, ST_READY, ST_XFER} state_t;
endpackage

// File: rtl/boreal_sync_edge.sv
// Two-flop synchronizer with one extra history flop for rise/fall pulses.
module boreal_sync_edge #(
  parameter logic RST_VAL = 1'b0
)(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= {3{RST_VAL}};
    else     sr <= {sr[1:0], din};
  end

  assign q    = sr[1];
  assign rise =  sr[1] & ~sr[2];
  assign fall = ~sr[1] &  sr[2];
endmodule

// File: rtl/boreal_ads_emulator.sv
// Emulates an ADC frame source: periodic DRDY, 33-word frame served over a
// CPOL=0/CPHA=1 SPI target, with command capture and overrun/short-read flags.
module boreal_ads_emulator
  import boreal_pkg::*;
#(
  parameter int FRAME_BITS  = boreal_pkg::FRAME_BITS,
  parameter int DRDY_PERIOD = 25_000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pattern_sel,
  input  logic [23:0] test_word,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        drdy_n,
  output logic [15:0] frame_count,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        overrun,
  output logic        short_frame
);
  localparam int NUM_WORDS = FRAME_BITS / WORD_BITS;
  localparam int BCW = $clog2(FRAME_BITS + 1);
  localparam int PCW = (DRDY_PERIOD > 1) ? $clog2(DRDY_PERIOD) : 1;

  logic unused_sclk_q, unused_mosi_rise, unused_mosi_fall;
  logic sclk_rise, sclk_fall, cs_q, cs_rise, cs_fall, mosi_q;

  boreal_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  boreal_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  boreal_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .q(mosi_q), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

  state_t state, state_nxt, st_eff;
  logic [PCW-1:0]        per_cnt;
  logic [15:0]           sample_cnt, sample_nxt;
  logic [FRAME_BITS-1:0] frame_buf, frame_new, shift_reg;
  logic [BCW-1:0]        bit_cnt;
  logic [3:0]            cmd_cnt;
  logic [6:0]            cmd_sr;
  logic                  miso_r;
  logic wrap, load_buf, set_ovr, drdy_set, frame_end, in_xfer;

  assign wrap       = enable && (per_cnt == PCW'(DRDY_PERIOD - 1));
  assign sample_nxt = sample_cnt + 16'd1;
  assign in_xfer    = (state == ST_XFER) && !cs_q;

  // Frame image for the sample about to be published.
  always_comb begin
    frame_new = '0;
    frame_new[FRAME_BITS-1 -: WORD_BITS] = STATUS_WORD;
    for (int i = 1; i < NUM_WORDS; i++)
      frame_new[FRAME_BITS-1-i*WORD_BITS -: WORD_BITS] =
        pattern_sel ? test_word : {sample_nxt, 8'(i)};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A chip-select release is retired before a coincident period wrap.
  always_comb begin
    st_eff    = state;
    load_buf  = 1'b0;
    set_ovr   = 1'b0;
    drdy_set  = 1'b0;
    frame_end = 1'b0;
    if (cs_rise && state == ST_XFER) begin
      st_eff    = ST_IDLE;
      frame_end = 1'b1;
    end
    state_nxt = st_eff;
    if (wrap) begin
      case (st_eff)
        ST_IDLE:  begin load_buf = 1'b1; drdy_set = 1'b1; state_nxt = ST_READY; end
        ST_READY: begin load_buf = 1'b1; set_ovr = 1'b1; end
        default:  set_ovr = 1'b1;
      endcase
    end
    if (cs_fall) state_nxt = ST_XFER;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt     <= '0;
      sample_cnt  <= '0;
      frame_buf   <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      miso_r      <= 1'b0;
      cmd_cnt     <= '0;
      cmd_sr      <= '0;
      cmd_byte    <= '0;
      cmd_valid   <= 1'b0;
      drdy_n      <= 1'b1;
      overrun     <= 1'b0;
      short_frame <= 1'b0;
      frame_count <= '0;
    end else begin
      cmd_valid <= 1'b0;
      if (enable) per_cnt <= wrap ? '0 : per_cnt + 1'b1;
      if (wrap)     sample_cnt <= sample_nxt;
      if (load_buf) frame_buf  <= frame_new;
      if (set_ovr)  overrun    <= 1'b1;

      if (cs_fall)       drdy_n <= 1'b1;
      else if (drdy_set) drdy_n <= 1'b0;

      if (cs_fall) begin
        shift_reg <= frame_buf;
        bit_cnt   <= '0;
        miso_r    <= 1'b0;
        cmd_cnt   <= '0;
      end else if (frame_end) begin
        miso_r <= 1'b0;
      end else begin
        if (sclk_rise && in_xfer) begin
          if (bit_cnt < BCW'(FRAME_BITS)) begin
            {miso_r, shift_reg} <= {shift_reg, 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            miso_r <= 1'b0;
          end
        end
        if (sclk_fall && in_xfer && cmd_cnt < 4'd8) begin
          cmd_sr  <= {cmd_sr[5:0], mosi_q};
          cmd_cnt <= cmd_cnt + 1'b1;
          if (cmd_cnt == 4'd7) begin
            cmd_byte  <= {cmd_sr, mosi_q};
            cmd_valid <= 1'b1;
          end
        end
      end

      if (frame_end) begin
        if (bit_cnt == BCW'(FRAME_BITS)) frame_count <= frame_count + 16'd1;
        else                             short_frame <= 1'b1;
      end
    end
  end

  assign miso = miso_r & ~cs_q;
endmodule

// File: tb/tb_boreal_ads_emulator.sv
// Self-checking bench: vector table of read scenarios, randomized reads
// against a frame/sample model, and a reset-during-transfer sequence.
module tb_boreal_ads_emulator;
  localparam int FB = 792;
  localparam int P  = 2000;

  logic clk = 1'b0;
  logic rst, enable, pattern_sel, sclk, cs_n, mosi;
  logic [23:0] test_word;
  logic miso, drdy_n, cmd_valid, overrun, short_frame;
  logic [15:0] frame_count;
  logic [7:0]  cmd_byte;

  boreal_ads_emulator #(.FRAME_BITS(FB), .DRDY_PERIOD(P)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .test_word(test_word), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .drdy_n(drdy_n), .frame_count(frame_count),
    .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .overrun(overrun),
    .short_frame(short_frame));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cv_total = 0;
  logic rx_bits [0:1023];

  always @(negedge clk) if (cmd_valid === 1'b1) cv_total++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_word(int i, logic [15:0] s, bit psel, logic [23:0] tw);
    if (i == 0) return 24'hC00000;
    if (psel)   return tw;
    return {s, 8'(i)};
  endfunction

  function automatic logic [23:0] rx_word(int w);
    logic [23:0] r = '0;
    for (int k = 0; k < 24; k++) r = {r[22:0], rx_bits[24*w+k]};
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs n sample periods; reports the cycle at which drdy_n first fell.
  task automatic wait_periods(input int n, output int first);
    first = 0;
    enable = 1'b1;
    for (int c = 1; c <= n * P; c++) begin
      @(negedge clk);
      if (drdy_n == 1'b0 && first == 0) first = c;
    end
    enable = 1'b0;
  endtask

  task automatic spi_bits(input int n, input logic [7:0] cmd);
    for (int b = 0; b < n; b++) begin
      sclk = 1'b1;
      mosi = (b < 8) ? cmd[7-b] : 1'($urandom);
      repeat (4) @(negedge clk);
      rx_bits[b] = miso;
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    mosi = 1'b0;
  endtask

  // One complete read; checks data words against the model expectation.
  task automatic read_and_check(input string tag, input int nbits, input logic [7:0] cmd,
                                input logic [15:0] s, input bit psel, input logic [23:0] tw);
    int cv0, nclk, nw;
    chk({tag, "_drdy_low"}, 32'(drdy_n), 0);
    cv0 = cv_total;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_drdy_clr"}, 32'(drdy_n), 1);
    nclk = (nbits == FB) ? FB + 4 : nbits;
    spi_bits(nclk, cmd);
    nw = nbits / 24;
    for (int w = 0; w < nw; w++)
      chk($sformatf("%s_word%0d", tag, w), 32'(rx_word(w)), 32'(exp_word(w, s, psel, tw)));
    if (nbits == FB)
      for (int k = FB; k < FB + 4; k++) chk($sformatf("%s_tail%0d", tag, k), 32'(rx_bits[k]), 0);
    cs_n = 1'b1;
    repeat (5) @(negedge clk);
    chk({tag, "_miso_idle"}, 32'(miso), 0);
    if (nbits >= 8) begin
      chk({tag, "_cmd_byte"}, 32'(cmd_byte), 32'(cmd));
      chk({tag, "_cmd_pulses"}, 32'(cv_total - cv0), 1);
    end
  endtask

  typedef struct {
    bit          psel;
    logic [23:0] tw;
    int          periods;
    int          nbits;
    logic [7:0]  cmd;
    bit          exp_ovr;
    bit          exp_short;
    logic [15:0] exp_fc;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int first;
    logic [15:0] m_s, m_fc;
    bit m_ovr, m_short, psel;
    logic [23:0] tw;
    int per, nb;
    logic [7:0] cmd;

    vecs[0] = '{0, 24'h000000, 1, FB,  8'h12, 0, 0, 16'd1};
    vecs[1] = '{1, 24'hA5A5A5, 1, FB,  8'h3C, 0, 0, 16'd1};
    vecs[2] = '{0, 24'h000000, 2, 48,  8'h81, 1, 1, 16'd0};
    vecs[3] = '{0, 24'h000000, 1, 100, 8'hE7, 0, 1, 16'd0};

    pattern_sel = 1'b0; test_word = '0;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drdy_n", 32'(drdy_n), 1);
    chk("rst_miso", 32'(miso), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_cmd_byte", 32'(cmd_byte), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_short_frame", 32'(short_frame), 0);

    for (int v = 0; v < 4; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      do_reset();
      pattern_sel = vecs[v].psel; test_word = vecs[v].tw;
      wait_periods(vecs[v].periods, first);
      chk({tag, "_drdy_cycle"}, 32'(first), P);
      read_and_check(tag, vecs[v].nbits, vecs[v].cmd, 16'(vecs[v].periods),
                     vecs[v].psel, vecs[v].tw);
      chk({tag, "_overrun"}, 32'(overrun), 32'(vecs[v].exp_ovr));
      chk({tag, "_short"}, 32'(short_frame), 32'(vecs[v].exp_short));
      chk({tag, "_frame_count"}, 32'(frame_count), 32'(vecs[v].exp_fc));
      chk({tag, "_drdy_idle"}, 32'(drdy_n), 1);
    end

    // Randomized short reads; the model accumulates samples and sticky flags.
    do_reset();
    m_s = 0; m_fc = 0; m_ovr = 0; m_short = 0;
    for (int it = 0; it < 4; it++) begin
      string tag;
      tag = $sformatf("rnd%0d", it);
      psel = 1'($urandom); tw = 24'($urandom);
      per = $urandom_range(1, 2); nb = $urandom_range(24, 120); cmd = 8'($urandom);
      pattern_sel = psel; test_word = tw;
      wait_periods(per, first);
      chk({tag, "_drdy_cycle"}, 32'(first), P);
      m_s += 16'(per);
      if (per > 1) m_ovr = 1;
      m_short = 1;
      read_and_check(tag, nb, cmd, m_s, psel, tw);
      chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
      chk({tag, "_short"}, 32'(short_frame), 32'(m_short));
      chk({tag, "_frame_count"}, 32'(frame_count), 32'(m_fc));
    end

    // Reset in the middle of a transfer.
    do_reset();
    pattern_sel = 1'b0;
    wait_periods(2, first);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(400, 8'h5A);
    chk("mid_cmd_before", 32'(cmd_byte), 32'h5A);
    chk("mid_ovr_before", 32'(overrun), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_drdy_n", 32'(drdy_n), 1);
    chk("mid_miso", 32'(miso), 0);
    chk("mid_cmd_byte", 32'(cmd_byte), 0);
    chk("mid_cmd_valid", 32'(cmd_valid), 0);
    chk("mid_overrun", 32'(overrun), 0);
    chk("mid_short", 32'(short_frame), 0);
    chk("mid_frame_count", 32'(frame_count), 0);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_short", 32'(short_frame), 0);
    chk("post_frame_count", 32'(frame_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
